// File: rtl/rambam_pkg.sv
// Shared types and ring arithmetic for the masked GF(2)[x]/(P*Q) datapath.
// Vectors are [0:ELEM_W-1]; index i holds the coefficient of x^i.
package rambam_pkg;

    localparam int D      = 4;
    localparam int ELEM_W = 8 + D;

    typedef logic [0:ELEM_W-1] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // P = x^8+x^4+x^3+x+1, Q = x^4+x+1.
    // P*Q = x^12 + x^9+x^7+x^4+x^3+x^2+1 (low part 0x29D with x^i at 2^i).
    // Listed here from x^0 on the left to x^11 on the right.
    localparam elem_t PQ_LOW_REF = 12'b1011_1001_0100;

    // Multiply by x in the ring: shift toward higher degree, and fold the
    // overflowing x^ELEM_W term back in as the low part of the modulus.
    function automatic elem_t xtime_pq(elem_t v, elem_t pq_low);
        elem_t r;
        r[0] = 1'b0;
        for (int i = 1; i < ELEM_W; i++) begin
            r[i] = v[i-1];
        end
        if (v[ELEM_W-1]) begin
            r = r ^ pq_low;
        end
        return r;
    endfunction

endpackage

// File: rtl/pq_serial_mult.sv
// Bit-serial multiplier in GF(2)[x]/(P*Q), one shift-and-add step per cycle.
// Ports: clk, rst (async, high); in_valid/in_ready with a, b;
//        out_valid/out_ready with out = a*b mod P*Q (registered).
//        b is scanned from x^(7+d) down to x^0. d must match rambam_pkg::D.
module pq_serial_mult
    import rambam_pkg::*;
#(
    parameter int           d      = D,
    parameter bit [0:7+d]   PQ_LOW = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:7+d] a,
    input  logic [0:7+d] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:7+d] out
);

    localparam int W  = 8 + d;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    state_t        state;
    state_t        state_nx;
    logic [0:W-1]  a_reg;
    logic [0:W-1]  b_reg;
    logic [0:W-1]  acc;
    logic [0:W-1]  acc_step;
    logic [0:W-1]  out_q;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;

    // Horner step: acc*x + b_i*a, always kept fully reduced.
    assign acc_step = xtime_pq(acc, PQ_LOW) ^ (b_reg[cnt] ? a_reg : '0);
    assign out      = out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= CNT_TOP;
        end else if (state == BUSY) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
            // out only moves on entry to DONE, so it is stable while held
            if (last) begin
                out_q <= acc_step;
            end
        end
    end

endmodule

// File: tb/tb_pq_serial_mult.sv
// Self-checking bench for pq_serial_mult (d=4, P*Q = 0x129D).
// Directed table, backpressure, async reset abort and random regression.
module tb_pq_serial_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:11] a;
    logic [0:11] b;
    logic        out_valid;
    logic        out_ready;
    logic [0:11] out;

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] sb[$];

    function automatic logic [0:11] to_p(logic [11:0] v);
        logic [0:11] r;
        for (int i = 0; i < 12; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [11:0] from_p(logic [0:11] v);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = v[i];
        return r;
    endfunction

    localparam logic [0:11] PQ = to_p(12'h29D);

    pq_serial_mult #(
        .d      (4),
        .PQ_LOW (PQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    // Full carry-less product, then long division by 0x129D.
    function automatic logic [11:0] ref_mul(logic [11:0] x, logic [11:0] y);
        logic [23:0] p;
        p = '0;
        for (int i = 0; i < 12; i++)
            if (y[i]) p = p ^ (24'(x) << i);
        for (int i = 23; i >= 12; i--)
            if (p[i]) p = p ^ (24'h129D << (i - 12));
        return p[11:0];
    endfunction

    function automatic logic [7:0] mod_p(logic [15:0] x);
        logic [15:0] p;
        p = x;
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] gf8_mul(logic [7:0] x, logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (16'(x) << i);
        return mod_p(p);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Runs one job; gap = out_ready-low cycles after
    // out_valid; noise drives a competing in_valid during the gap.
    task automatic run_job(input logic [11:0] av, input logic [11:0] bv,
                           input int gap, input bit noise,
                           output logic [11:0] got, output int cyc);
        int n;
        logic [11:0] held;
        logic [11:0] exp;
        got = '0;
        cyc = 0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        a = to_p(av);
        b = to_p(bv);
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(ref_mul(av, bv));
        @(negedge clk);
        in_valid = 1'b0;
        a = to_p(12'($urandom));
        b = to_p(12'($urandom));
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            void'(sb.pop_front());
            return;
        end
        held = from_p(out);
        for (int g = 0; g < gap; g++) begin
            if (noise) begin
                in_valid = 1'b1;
                a = to_p(12'($urandom));
                b = to_p(12'($urandom));
            end
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_out", 32'(from_p(out)), 32'(held));
            if (noise) chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        got = from_p(out);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            chk("product", 32'(got), 32'(exp));
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("valid_drop", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] exp;
        int          gap;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] got;
        logic [11:0] g_ab;
        logic [11:0] g_ba;
        int          cyc;
        bit          seen;

        tbl[0] = '{12'h001, 12'hABC, 12'hABC, 0};
        tbl[1] = '{12'h002, 12'h800, 12'h29D, 1};
        tbl[2] = '{12'h000, 12'hFFF, 12'h000, 0};
        tbl[3] = '{12'h5A3, 12'h0C7, ref_mul(12'h5A3, 12'h0C7), 2};
        tbl[4] = '{12'h0C7, 12'h5A3, ref_mul(12'h5A3, 12'h0C7), 0};
        tbl[5] = '{12'hFFF, 12'hFFF, ref_mul(12'hFFF, 12'hFFF), 3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(from_p(out)), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].a, tbl[i].b, tbl[i].gap, 1'b0, got, cyc);
            chk($sformatf("table_%0d", i), 32'(got), 32'(tbl[i].exp));
            if (i == 0) chk("latency", 32'(cyc), 32'd13);
            if (i == 3) g_ab = got;
            if (i == 4) g_ba = got;
        end
        chk("commutative", 32'(g_ab), 32'(g_ba));

        // Backpressure with a competing request while DONE is held.
        run_job(12'h3C5, 12'h9A1, 20, 1'b1, got, cyc);
        chk("bp_product", 32'(got), 32'(ref_mul(12'h3C5, 12'h9A1)));
        run_job(12'h123, 12'h456, 0, 1'b0, got, cyc);
        chk("after_bp", 32'(got), 32'(ref_mul(12'h123, 12'h456)));

        // Async reset five cycles into a job.
        a = to_p(12'h777);
        b = to_p(12'hEEE);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out", 32'(from_p(out)), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        run_job(12'hBEE, 12'h0F1, 0, 1'b0, got, cyc);
        chk("after_abort", 32'(got), 32'(ref_mul(12'hBEE, 12'h0F1)));

        // Random regression, including the mod_P view of each result.
        for (int i = 0; i < 1000; i++) begin
            logic [11:0] ra;
            logic [11:0] rb;
            ra = 12'($urandom);
            rb = 12'($urandom);
            run_job(ra, rb, $urandom_range(0, 3), 1'b0, got, cyc);
            chk("mod_p", 32'(mod_p(16'(got))),
                32'(gf8_mul(mod_p(16'(ra)), mod_p(16'(rb)))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pq_serial_mult.md
# pq_serial_mult

Bit-serial multiplier in the redundant ring GF(2)[x]/(P·Q), where deg P = 8 and deg Q = d. It takes two (8+d)-bit masked operands and produces their (8+d)-bit product reduced modulo P·Q. It sits directly upstream of the mod_P reduction stage, whose input is exactly this block's output. It uses one shift-and-add step per cycle, trading latency for area against a fully combinational ring multiplier.

## Interface
Parameters:
- d, 4, degree of the masking polynomial Q; element width is 8+d.
- PQ_LOW, all-zero bit[0:7+d], coefficients x^0..x^(7+d) of the monic product P·Q; the x^(8+d) term is implicit.

Ports (all vectors [0:7+d], index i = coefficient of x^i):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair a/b present.
- in_ready  out  1  block can accept an operand pair.
- a  in  8+d  multiplicand.
- b  in  8+d  multiplier, scanned MSB (x^(7+d)) first.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- out  out  8+d  a·b mod P·Q.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a into a_reg and b into b_reg; clear acc; set cnt=7+d; go to BUSY.
- BUSY, one step per cycle:
  - acc ← xtime(acc) ^ (b_reg[cnt] ? a_reg : 0).
  - Decrement cnt.
  - After the step using cnt=0, go to DONE.
- xtime(v):
  - Shift up: r[i]=v[i-1] for i≥1, r[0]=0.
  - If v[7+d]=1, r ^= PQ_LOW.
  - Pure GF(2); no carries.
- DONE:
  - out_valid=1, out=acc.
  - On out_ready: go to IDLE.
  - Without out_ready: hold out and out_valid stable indefinitely.
- in_ready=0 in BUSY and DONE. in_valid is ignored there and no operands are captured.
- Single-entry: there is no overlap between one job's DONE and the next job's accept. The earliest new accept is the cycle after the handshake.
- Full reduction invariant: acc always has degree < 8+d, so out is the canonical residue mod P·Q.
- cnt width: $clog2(8+d).

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, out=0.
  - acc, a_reg, b_reg, cnt all 0.
- Reset mid-operation (BUSY or DONE) aborts immediately to the reset values. The partial product is discarded and no out_valid pulse is produced.
- Latency:
  - Accept edge at cycle T.
  - 8+d BUSY cycles, T+1 .. T+8+d.
  - out_valid=1 from cycle T+9+d (13 cycles after accept for d=4).
- Throughput: one product per 10+d cycles when out_ready is held high. That is 8+d BUSY cycles, 1 DONE cycle and 1 IDLE cycle.
- out is registered. It changes only on entry to DONE or on reset.
- Operands a and b need only be stable in the accept cycle.

## Structure
- Shared package (rambam_pkg):
  - parameter D.
  - ELEM_W = 8+D.
  - typedef elem_t = logic [0:ELEM_W-1].
  - State enum {IDLE, BUSY, DONE}.
  - PQ_LOW constant for the chosen P, Q.
  - Function xtime_pq (elem_t, PQ_LOW) → elem_t. This function is reused by any future serial ring stage.
- No sub-module. The datapath is one xtime plus one conditional XOR.
- The integration wrapper instantiates pq_serial_mult → mod_P, with out connected to mod_P.in.

## Test plan
Setup: d=4, P=x^8+x^4+x^3+x+1, Q=x^4+x+1, so P·Q=x^12+x^9+x^7+x^4+x^3+x^2+1. PQ_LOW hex is 0x29D, written with x^i weighted 2^i.

1. Identity: a=0x001, b=0xABC.
   - out=0xABC.
   - out_valid first seen 13 cycles after accept.
2. Single reduction: a=0x002, b=0x800 (x·x^11 = x^12).
   - out=0x29D.
3. Zero and commutativity:
   - a=0x000, b=0xFFF gives out=0x000.
   - a=0x5A3, b=0x0C7, then swapped: both outs are equal and match the software reference.
4. Backpressure: hold out_ready=0 for 20 cycles after out_valid rises.
   - out and out_valid stay stable.
   - in_ready=0 throughout.
   - A concurrent in_valid is ignored.
   - Releasing out_ready gives a handshake; in_ready=1 on the next cycle.
5. Reset mid-BUSY: assert rst asynchronously between clock edges, 5 cycles into a job.
   - Outputs take their reset values immediately.
   - No out_valid follows.
   - The next job gives the correct product.
6. Random regression: 1000 random a/b pairs with random out_ready gaps.
   - Each out equals the software GF(2) product mod 0x129D.
   - mod_P(out) equals (a mod P)·(b mod P) in GF(2^8).
